counter_monitor: RTL and testbench
==================================

Name: counter_monitor

Overview:
- Observing end of the free-running counter interface: samples a counter's WIDTH-bit output and checks that each new sample is exactly previous+1 modulo 2^WIDTH.
- Locks onto a valid count sequence and reports lock status, per-error pulses, saturating error and wrap statistics.
- Sits beside any counter_simple-style block, or in its bench, as a self-checking consumer of the counter output.

Parameters:
- WIDTH, 4, width of observed counter value q.
- SYNC_LEN, 2, consecutive correct increments required to enter LOCKED (>=1).
- ERR_LIMIT, 3, consecutive mismatches in LOCKED that drop lock (>=1).
- CNT_W, 8, width of err_count and wrap_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; q is evaluated only on edges where en=1.
- q  in  WIDTH  observed counter value.
- locked  out  1  1 while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  CNT_W  saturating count of LOCKED mismatches.
- wrap_count  out  CNT_W  saturating count of correct all-ones->0 transitions seen in LOCKED.
- last_q  out  WIDTH  most recently accepted sample.

Behaviour:
- Reset (async, immediate, regardless of clk): state=UNLOCKED, all outputs 0, internal match_cnt=0, miss_cnt=0, prev=0.
- All outputs are registered and update on the same rising edge that samples q; visible one cycle after the sample is presented.
- en=0: no state, counter or prev change; err_pulse=0 on that edge.
- Expected value: exp = (prev + 1) mod 2^WIDTH; all-ones wraps to 0 by truncation.
- prev <= q on every en=1 edge, in every state; last_q mirrors prev.
- UNLOCKED: first en=1 sample stores prev -> SYNCING, match_cnt=0. No comparison on this sample.
- SYNCING: q==exp -> match_cnt+1; when match_cnt reaches SYNC_LEN -> LOCKED, miss_cnt=0, locked=1 from that edge. q!=exp -> match_cnt=0, stay SYNCING. No error reporting in SYNCING.
- LOCKED: q==exp -> miss_cnt=0; if prev was all-ones, wrap_count+1 (saturate at 2^CNT_W-1). q!=exp, including a held value (q==prev) -> err_pulse=1 for exactly that edge, err_count+1 (saturating), miss_cnt+1; when miss_cnt reaches ERR_LIMIT -> SYNCING, match_cnt=0, locked=0 on that same edge.
- The mismatching sample becomes prev, so a counter that jumps and then resumes counting from the new value recovers on the next match.
- Saturated counters hold their value. They are cleared only by reset.
- Reset asserted mid-sequence overrides everything. On release, monitoring restarts from UNLOCKED; the first sample after release is never flagged.

Test Plan:
- Reset, then en=1 with q=0,1,2,...,15,0,1 one per cycle -> locked=1 after the edge sampling q=2; err_count=0; wrap_count=1 after the edge sampling the 0 following 15; last_q=1 at end.
- Locked, feed 5,6,9,10,11 -> single err_pulse on the edge sampling 9; err_count=1; locked stays 1 (miss_cnt cleared by 10).
- Locked, q held at 7 for 4 samples after 6 -> err_pulse on the 2nd, 3rd and 4th samples of 7 (the 1st is 6->7, a match); locked drops on the 4th; err_count=3. Then 8,9 -> locked=1 again after sampling 9.
- Locked sequence with en toggling 1,0,1,0 and q=junk (e.g. 0xA) on en=0 cycles -> junk ignored; no err_pulse; locked and counters unchanged.
- CNT_W=2, ERR_LIMIT=8: lock, then 5 non-consecutive mismatches (each followed by a correct increment) -> err_count saturates at 3; 5 err_pulses still emitted.
- Assert reset between clock edges while LOCKED with err_count=2 -> all outputs 0 immediately, before the next edge. Release, then feed 12 -> no err_pulse; state SYNCING.

Source files
------------

// File: rtl/counter_monitor.sv
// Observes a free-running counter and checks that each accepted sample equals the previous one plus one.
// Reports lock status, per-mismatch pulses, and saturating error and wrap statistics.
module counter_monitor #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SYNC_LEN  = 2,
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_q
);

    localparam int unsigned MATCH_W = (SYNC_LEN  > 1) ? $clog2(SYNC_LEN + 1)  : 1;
    localparam int unsigned MISS_W  = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_SYNCING  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic [WIDTH-1:0]   prev_q,      prev_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0]   wrap_cnt_q,  wrap_cnt_d;
    logic               locked_q,    locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0]   exp_val;
    logic               is_match;

    // State and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_UNLOCKED;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            prev_q      <= '0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            prev_q      <= prev_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Next-state and statistics update; nothing moves on edges with en low.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        prev_d      = prev_q;
        err_cnt_d   = err_cnt_q;
        wrap_cnt_d  = wrap_cnt_q;
        err_pulse_d = 1'b0;
        exp_val     = prev_q + WIDTH'(1);
        is_match    = (q == exp_val);

        if (en) begin
            prev_d = q;
            case (state_q)
                S_UNLOCKED: begin
                    state_d     = S_SYNCING;
                    match_cnt_d = '0;
                end
                S_SYNCING: begin
                    if (is_match) begin
                        if (match_cnt_q == MATCH_W'(SYNC_LEN - 1)) begin
                            state_d     = S_LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (is_match) begin
                        miss_cnt_d = '0;
                        if ((prev_q == {WIDTH{1'b1}}) && (wrap_cnt_q != {CNT_W{1'b1}})) begin
                            wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        // Too many back-to-back misses: fall back and resynchronise.
                        if (miss_cnt_q == MISS_W'(ERR_LIMIT - 1)) begin
                            state_d     = S_SYNCING;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = S_UNLOCKED;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;
    assign last_q     = prev_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: a default instance plus a CNT_W=2 / ERR_LIMIT=8 instance
// for saturation behaviour.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, en_b;
    logic [3:0] q_a, q_b;

    logic       locked_a, pulse_a;
    logic [7:0] err_a, wrap_a;
    logic [3:0] last_a;
    logic       locked_b, pulse_b;
    logic [1:0] err_b, wrap_b;
    logic [3:0] last_b;

    always #5 clk = ~clk;

    counter_monitor dut (
        .clk(clk), .reset(reset), .en(en_a), .q(q_a),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(err_a),
        .wrap_count(wrap_a), .last_q(last_a)
    );

    counter_monitor #(.WIDTH(4), .SYNC_LEN(2), .ERR_LIMIT(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en_b), .q(q_b),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(err_b),
        .wrap_count(wrap_b), .last_q(last_b)
    );

    typedef struct packed {
        logic       sel;
        logic       locked;
        logic       pulse;
        logic [7:0] err;
        logic [7:0] wrap;
        logic [3:0] last;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t sample(input logic sel);
        obs_t o;
        if (sel) o = '{1'b1, locked_b, pulse_b, 8'(err_b), 8'(wrap_b), last_b};
        else     o = '{1'b0, locked_a, pulse_a, err_a, wrap_a, last_a};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got locked=%0d pulse=%0d err=%0d wrap=%0d last=%0d required locked=%0d pulse=%0d err=%0d wrap=%0d last=%0d",
                     name, got.locked, got.pulse, got.err, got.wrap, got.last,
                     want.locked, want.pulse, want.err, want.wrap, want.last);
        end
    endtask

    task automatic drive_a(input logic e, input logic [3:0] v, input logic lk, input logic p,
                           input int er, input int wr, input logic [3:0] l);
        @(negedge clk);
        en_a = e;
        q_a  = v;
        @(posedge clk);
        #1;
        sb.push_back('{1'b0, lk, p, 8'(er), 8'(wr), l});
    endtask

    task automatic drive_b(input logic e, input logic [3:0] v, input logic lk, input logic p,
                           input int er, input int wr, input logic [3:0] l);
        @(negedge clk);
        en_b = e;
        q_b  = v;
        @(posedge clk);
        #1;
        sb.push_back('{1'b1, lk, p, 8'(er), 8'(wr), l});
    endtask

    // Asserts reset between clock edges and checks outputs clear before the next edge.
    task automatic mid_reset(input string name);
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        #1 reset = 1'b1;
        #1;
        check({name, "_a"}, sample(1'b0), '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0});
        check({name, "_b"}, sample(1'b1), '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0});
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        q_a   = '0;
        q_b   = '0;
        fork
            begin : monitor
                obs_t e;
                forever begin
                    @(negedge clk);
                    while (sb.size() > 0) begin
                        e = sb.pop_front();
                        check($sformatf("%s_vec%0d", e.sel ? "sat" : "main", checks),
                              sample(e.sel), e);
                    end
                end
            end
            begin : stimulus
                int wait_cnt;
                #3;
                check("por_a", sample(1'b0), '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0});
                check("por_b", sample(1'b1), '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0});
                @(negedge clk);
                reset = 1'b0;

                // Count 0..15,0,1: lock after q=2, one wrap after 15->0.
                for (int i = 0; i < 18; i++)
                    drive_a(1'b1, 4'(i % 16), i >= 2, 1'b0, 0, (i >= 16) ? 1 : 0, 4'(i % 16));

                // Single jump 6->9 then recover.
                drive_a(1'b1, 4'd2,  1'b1, 1'b0, 0, 1, 4'd2);
                drive_a(1'b1, 4'd3,  1'b1, 1'b0, 0, 1, 4'd3);
                drive_a(1'b1, 4'd4,  1'b1, 1'b0, 0, 1, 4'd4);
                drive_a(1'b1, 4'd5,  1'b1, 1'b0, 0, 1, 4'd5);
                drive_a(1'b1, 4'd6,  1'b1, 1'b0, 0, 1, 4'd6);
                drive_a(1'b1, 4'd9,  1'b1, 1'b1, 1, 1, 4'd9);
                drive_a(1'b1, 4'd10, 1'b1, 1'b0, 1, 1, 4'd10);
                drive_a(1'b1, 4'd11, 1'b1, 1'b0, 1, 1, 4'd11);

                // Held value: three misses drop lock, then relock after 8,9.
                mid_reset("rst1");
                drive_a(1'b1, 4'd4, 1'b0, 1'b0, 0, 0, 4'd4);
                drive_a(1'b1, 4'd5, 1'b0, 1'b0, 0, 0, 4'd5);
                drive_a(1'b1, 4'd6, 1'b1, 1'b0, 0, 0, 4'd6);
                drive_a(1'b1, 4'd7, 1'b1, 1'b0, 0, 0, 4'd7);
                drive_a(1'b1, 4'd7, 1'b1, 1'b1, 1, 0, 4'd7);
                drive_a(1'b1, 4'd7, 1'b1, 1'b1, 2, 0, 4'd7);
                drive_a(1'b1, 4'd7, 1'b0, 1'b1, 3, 0, 4'd7);
                drive_a(1'b1, 4'd8, 1'b0, 1'b0, 3, 0, 4'd8);
                drive_a(1'b1, 4'd9, 1'b1, 1'b0, 3, 0, 4'd9);

                // en toggling with junk on disabled cycles.
                drive_a(1'b1, 4'd10, 1'b1, 1'b0, 3, 0, 4'd10);
                drive_a(1'b0, 4'hA,  1'b1, 1'b0, 3, 0, 4'd10);
                drive_a(1'b1, 4'd11, 1'b1, 1'b0, 3, 0, 4'd11);
                drive_a(1'b0, 4'h3,  1'b1, 1'b0, 3, 0, 4'd11);
                drive_a(1'b1, 4'd12, 1'b1, 1'b0, 3, 0, 4'd12);

                // Reach LOCKED with err_count=2, reset mid-cycle, restart.
                mid_reset("rst2");
                drive_a(1'b1, 4'd0,  1'b0, 1'b0, 0, 0, 4'd0);
                drive_a(1'b1, 4'd1,  1'b0, 1'b0, 0, 0, 4'd1);
                drive_a(1'b1, 4'd2,  1'b1, 1'b0, 0, 0, 4'd2);
                drive_a(1'b1, 4'd5,  1'b1, 1'b1, 1, 0, 4'd5);
                drive_a(1'b1, 4'd6,  1'b1, 1'b0, 1, 0, 4'd6);
                drive_a(1'b1, 4'd9,  1'b1, 1'b1, 2, 0, 4'd9);
                drive_a(1'b1, 4'd10, 1'b1, 1'b0, 2, 0, 4'd10);
                mid_reset("rst_locked");
                drive_a(1'b1, 4'd12, 1'b0, 1'b0, 0, 0, 4'd12);
                drive_a(1'b1, 4'd13, 1'b0, 1'b0, 0, 0, 4'd13);
                drive_a(1'b1, 4'd14, 1'b1, 1'b0, 0, 0, 4'd14);

                // Saturation instance: five isolated misses, err_count stops at 3.
                drive_a(1'b0, 4'd0, 1'b1, 1'b0, 0, 0, 4'd14);
                drive_b(1'b1, 4'd0,  1'b0, 1'b0, 0, 0, 4'd0);
                drive_b(1'b1, 4'd1,  1'b0, 1'b0, 0, 0, 4'd1);
                drive_b(1'b1, 4'd2,  1'b1, 1'b0, 0, 0, 4'd2);
                drive_b(1'b1, 4'd5,  1'b1, 1'b1, 1, 0, 4'd5);
                drive_b(1'b1, 4'd6,  1'b1, 1'b0, 1, 0, 4'd6);
                drive_b(1'b1, 4'd9,  1'b1, 1'b1, 2, 0, 4'd9);
                drive_b(1'b1, 4'd10, 1'b1, 1'b0, 2, 0, 4'd10);
                drive_b(1'b1, 4'd13, 1'b1, 1'b1, 3, 0, 4'd13);
                drive_b(1'b1, 4'd14, 1'b1, 1'b0, 3, 0, 4'd14);
                drive_b(1'b1, 4'd1,  1'b1, 1'b1, 3, 0, 4'd1);
                drive_b(1'b1, 4'd2,  1'b1, 1'b0, 3, 0, 4'd2);
                drive_b(1'b1, 4'd6,  1'b1, 1'b1, 3, 0, 4'd6);
                drive_b(1'b1, 4'd7,  1'b1, 1'b0, 3, 0, 4'd7);
                // Four wraps through 15->0; the 2-bit wrap count holds at 3.
                for (int i = 8; i < 72; i++)
                    drive_b(1'b1, 4'(i % 16), 1'b1, 1'b0, 3, (i / 16 > 3) ? 3 : i / 16, 4'(i % 16));

                wait_cnt = 0;
                while (sb.size() > 0 && wait_cnt < 10) begin
                    @(negedge clk);
                    #1;
                    wait_cnt++;
                end
                if (sb.size() > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain got %0d pending required 0", sb.size());
                end
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
